ft232h_rx: RTL and testbench

FT232H_RX -- requirements
Module: ft232h_rx

---
 rtl/ft232h_pkg.sv | 15 +
 rtl/ft232h_rx_fifo.sv | 60 ++++++
 rtl/ft232h_rx.sv | 101 ++++++++++
 tb/tb_ft232h_rx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ft232h_pkg.sv
// Shared definitions for the FT232H synchronous-FIFO receive path.
// Holds the receive FSM state encoding and the default buffer depth and
// burst-start margin used by ft232h_rx.
package ft232h_pkg;

  localparam int unsigned DefDepth  = 16;
  localparam int unsigned DefMargin = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOe   = 2'd1,
    StRead = 2'd2
  } state_e;

endpackage

// File: rtl/ft232h_rx_fifo.sv
// Single-clock byte FIFO used as the FT232H receive buffer.
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset (pointers and level only)
//   push_i, wdata_i write request and byte; ignored when full unless pop_i is also set
//   pop_i           read request; advances the head when non-empty
//   rdata_o         head byte (combinational read of the storage array)
//   full_o, empty_o occupancy flags
//   level_o         occupancy, 0..Depth
module ft232h_rx_fifo #(
  parameter int unsigned Depth = 16,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned LvlW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic [7:0]      wdata_i,
  input  logic            pop_i,
  output logic [7:0]      rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [LvlW-1:0] level_o
);

  logic [7:0]      mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [LvlW-1:0] level_q;
  logic            do_push, do_pop;

  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rptr_q];

  // A push into a full buffer is accepted when the head leaves on the same edge.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
        level_q <= level_q + LvlW'(1);
      end else if (!do_push && do_pop) begin
        level_q <= level_q - LvlW'(1);
      end
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ft232h_rx.sv
// FT232H synchronous-FIFO receive controller.
// Runs read bursts (IDLE -> OE -> READ) against the FT232H and streams the
// captured bytes out through a small buffer.
// Ports:
//   clock, rst        FT232H CLKOUT, asynchronous active-high reset
//   rxf_n, data       FT232H data-available flag and input data bus
//   oe_n, rd_n        FT232H output enable and read strobe (registered)
//   st_data/valid/ready  byte stream out of the buffer
//   rx_level          buffer occupancy
//   overflow          sticky: a byte arrived while the buffer was full
module ft232h_rx
  import ft232h_pkg::*;
#(
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned MARGIN = DefMargin,
  localparam int unsigned LvlW  = $clog2(DEPTH) + 1
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            rxf_n,
  input  logic [7:0]      data,
  output logic            oe_n,
  output logic            rd_n,
  output logic [7:0]      st_data,
  output logic            st_valid,
  input  logic            st_ready,
  output logic [LvlW-1:0] rx_level,
  output logic            overflow
);

  state_e          state_q;
  logic            oe_n_q, rd_n_q, overflow_q;
  logic            capture, pop, push_ok, full, empty;
  logic            can_start, must_stop;
  logic [LvlW-1:0] level_after;

  assign oe_n     = oe_n_q;
  assign rd_n     = rd_n_q;
  assign overflow = overflow_q;
  assign st_valid = ~empty;

  // The device drives a byte on every edge where our strobe and its flag are both low.
  assign capture = ~rd_n_q & ~rxf_n;
  assign pop     = st_valid & st_ready;
  assign push_ok = capture & (~full | pop);

  assign level_after = rx_level + LvlW'(push_ok) - LvlW'(pop);
  assign can_start   = ~rxf_n & ((LvlW'(DEPTH) - rx_level) >= LvlW'(MARGIN));
  // Stop with one free slot left: the byte captured on the exit edge still fits.
  assign must_stop   = rxf_n | (level_after >= LvlW'(DEPTH - 1));

  ft232h_rx_fifo #(
    .Depth(DEPTH)
  ) u_fifo (
    .clk_i  (clock),
    .rst_i  (rst),
    .push_i (capture),
    .wdata_i(data),
    .pop_i  (pop),
    .rdata_o(st_data),
    .full_o (full),
    .empty_o(empty),
    .level_o(rx_level)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      oe_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (capture && full && !pop) overflow_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (can_start) begin
            state_q <= StOe;
            oe_n_q  <= 1'b0;
          end
        end
        StOe: begin
          state_q <= StRead;
          rd_n_q  <= 1'b0;
        end
        StRead: begin
          if (must_stop) begin
            state_q <= StIdle;
            rd_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          rd_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ft232h_rx.sv
module tb_ft232h_rx;

  localparam int unsigned LvlW = 5;

  logic            clock = 1'b0;
  logic            rst, rxf_n, st_ready;
  logic            oe_n, rd_n, st_valid, overflow;
  logic [7:0]      data, st_data;
  logic [LvlW-1:0] rx_level;

  int checks = 0;
  int errors = 0;

  always #8 clock = ~clock;

  ft232h_rx #(
    .DEPTH (16),
    .MARGIN(4)
  ) dut (
    .clock   (clock),
    .rst     (rst),
    .rxf_n   (rxf_n),
    .data    (data),
    .oe_n    (oe_n),
    .rd_n    (rd_n),
    .st_data (st_data),
    .st_valid(st_valid),
    .st_ready(st_ready),
    .rx_level(rx_level),
    .overflow(overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // FT232H source model and stream sink.
  logic [7:0] src_q[$];
  logic [7:0] rcv_q[$];
  int         src_idx;

  task automatic load_src(input int n, input logic [7:0] base);
    src_q.delete();
    rcv_q.delete();
    for (int i = 0; i < n; i++) src_q.push_back(base + 8'(i));
    src_idx = 0;
    rxf_n   = 1'b0;
    data    = src_q[0];
  endtask

  task automatic step();
    logic       cap;
    logic       pp;
    logic [7:0] d;
    cap = !rd_n && !rxf_n;
    pp  = st_valid && st_ready;
    d   = st_data;
    tick();
    if (cap) src_idx++;
    if (pp) rcv_q.push_back(d);
    rxf_n = (src_idx >= src_q.size());
    data  = rxf_n ? 8'h00 : src_q[src_idx];
  endtask

  // Strobe protocol: rd_n low needs oe_n low, and oe_n falls exactly one edge before rd_n.
  logic oe_p1 = 1'b1, oe_p2 = 1'b1, rd_p1 = 1'b1;
  always @(negedge clock) begin
    if (!rst) begin
      if (!rd_n) begin
        checks++;
        if (oe_n !== 1'b0) begin
          errors++;
          $display("FAIL rd_implies_oe actual oe_n=%b required 0", oe_n);
        end
      end
      if (!rd_n && rd_p1) begin
        checks++;
        if (!(oe_p1 == 1'b0 && oe_p2 == 1'b1)) begin
          errors++;
          $display("FAIL oe_lead actual oe history=%b%b required 10", oe_p2, oe_p1);
        end
      end
    end
    oe_p2 = oe_p1;
    oe_p1 = oe_n;
    rd_p1 = rd_n;
  end

  typedef struct {
    logic       rxf_n;
    logic [7:0] data;
    logic       st_ready;
    logic       oe_n;
    logic       rd_n;
    logic       st_valid;
    logic [7:0] st_data;
    logic [4:0] level;
  } vec_t;

  vec_t       vecs[9];
  logic [7:0] exp_b;
  bit         done;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 5-byte burst, stream always ready
    vecs[0] = '{1'b0, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0};
    vecs[1] = '{1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0};
    vecs[2] = '{1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 5'd1};
    vecs[3] = '{1'b0, 8'h12, 1'b1, 1'b0, 1'b0, 1'b1, 8'h12, 5'd1};
    vecs[4] = '{1'b0, 8'h13, 1'b1, 1'b0, 1'b0, 1'b1, 8'h13, 5'd1};
    vecs[5] = '{1'b0, 8'h14, 1'b1, 1'b0, 1'b0, 1'b1, 8'h14, 5'd1};
    vecs[6] = '{1'b0, 8'h15, 1'b1, 1'b0, 1'b0, 1'b1, 8'h15, 5'd1};
    vecs[7] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0};
    vecs[8] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0};

    rst = 1'b1; rxf_n = 1'b1; data = 8'h00; st_ready = 1'b0;
    repeat (3) tick();
    chk("rst_oe_n", oe_n, 1);
    chk("rst_rd_n", rd_n, 1);
    chk("rst_valid", st_valid, 0);
    chk("rst_level", rx_level, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;
    tick();
    tick();
    chk("idle_no_rxf", oe_n, 1);

    for (int i = 0; i < 9; i++) begin
      rxf_n = vecs[i].rxf_n; data = vecs[i].data; st_ready = vecs[i].st_ready;
      tick();
      chk($sformatf("v%0d_oe_n", i), oe_n, vecs[i].oe_n);
      chk($sformatf("v%0d_rd_n", i), rd_n, vecs[i].rd_n);
      chk($sformatf("v%0d_valid", i), st_valid, vecs[i].st_valid);
      chk($sformatf("v%0d_level", i), rx_level, vecs[i].level);
      if (vecs[i].st_valid) chk($sformatf("v%0d_data", i), st_data, vecs[i].st_data);
    end

    // Backpressure: burst stops with one slot free, no restart until 4 free.
    st_ready = 1'b0;
    load_src(40, 8'h40);
    repeat (40) step();
    chk("bp_level", rx_level, 15);
    chk("bp_taken", src_idx, 15);
    chk("bp_overflow", overflow, 0);
    chk("bp_idle_oe", oe_n, 1);
    st_ready = 1'b1;
    step();
    step();
    st_ready = 1'b0;
    step();
    chk("bp_free3_level", rx_level, 13);
    chk("bp_free3_oe", oe_n, 1);
    st_ready = 1'b1;
    step();
    st_ready = 1'b0;
    chk("bp_free4_level", rx_level, 12);
    chk("bp_free4_oe_wait", oe_n, 1);
    step();
    chk("restart_oe", oe_n, 0);
    chk("restart_rd", rd_n, 1);
    st_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      step();
      done = (src_idx == 40) && (rx_level == 0) && rd_n;
    end
    chk("drain_done", done, 1);
    chk("rcv_count", rcv_q.size(), 40);
    for (int i = 0; i < rcv_q.size(); i++) chk($sformatf("rcv_%0d", i), rcv_q[i], 8'h40 + 8'(i));

    // Reset in the middle of a burst
    st_ready = 1'b0;
    load_src(10, 8'h80);
    repeat (4) step();
    chk("mid_rd_low", rd_n, 0);
    chk("mid_level", rx_level, 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_oe", oe_n, 1);
    chk("mid_rst_rd", rd_n, 1);
    chk("mid_rst_valid", st_valid, 0);
    chk("mid_rst_level", rx_level, 0);
    rxf_n = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rel_oe", oe_n, 1);

    // Full boundary and forced overflow through the push path
    st_ready = 1'b0;
    rxf_n = 1'b1;
    tick();
    force dut.capture = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data = 8'(i);
      tick();
    end
    release dut.capture;
    chk("full_level", rx_level, 16);
    chk("full_head", st_data, 8'h00);
    chk("full_overflow", overflow, 0);
    force dut.capture = 1'b1;
    data = 8'hA0;
    st_ready = 1'b1;
    tick();
    release dut.capture;
    st_ready = 1'b0;
    chk("pp_level", rx_level, 16);
    chk("pp_head", st_data, 8'h01);
    chk("pp_overflow", overflow, 0);
    force dut.capture = 1'b1;
    data = 8'hEE;
    tick();
    release dut.capture;
    chk("ovf_set", overflow, 1);
    chk("ovf_level", rx_level, 16);
    chk("ovf_head", st_data, 8'h01);
    st_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_b = (i < 15) ? 8'(i + 1) : 8'hA0;
      chk($sformatf("full_drain_%0d", i), st_data, exp_b);
      tick();
    end
    st_ready = 1'b0;
    chk("drained_level", rx_level, 0);
    chk("drained_valid", st_valid, 0);
    chk("ovf_sticky", overflow, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ovf_cleared", overflow, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
